// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - sequential signed 32x32 multiply / 32/32 divide, fixed 34-cycle latency
// Operands are handled as magnitudes; signs are reapplied in FIX.
module mult_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        MultCtrl,
  input  logic        DivCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MultOut,
  output logic        DivOut,
  output logic        divZero,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, MRUN, DRUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] opb_q, opb_d;
  logic        sign_q, sign_d;
  logic        rsign_q, rsign_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        mult_out_q, mult_out_d;
  logic        div_out_q, div_out_d;
  logic        div_zero_q, div_zero_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] add_sum;
  logic [32:0] rem_shift, rem_trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign abs_a = A[31] ? (~A + 32'd1) : A;
  assign abs_b = B[31] ? (~B + 32'd1) : B;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign add_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};

  // Divide: acc[31:0] shifts dividend bits out and quotient bits in.
  assign rem_shift = {rem_q, acc_q[31]};
  assign rem_trial = rem_shift - {1'b0, opb_q};

  assign prod_fix = sign_q  ? (~acc_q + 64'd1)        : acc_q;
  assign quo_fix  = sign_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
  assign rem_fix  = rsign_q ? (~rem_q + 32'd1)        : rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      acc_q      <= 64'd0;
      rem_q      <= 32'd0;
      opb_q      <= 32'd0;
      sign_q     <= 1'b0;
      rsign_q    <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      mult_out_q <= 1'b0;
      div_out_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opb_q      <= opb_d;
      sign_q     <= sign_d;
      rsign_q    <= rsign_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mult_out_q <= mult_out_d;
      div_out_q  <= div_out_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opb_d      = opb_q;
    sign_d     = sign_q;
    rsign_d    = rsign_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mult_out_d = 1'b0;
    div_out_d  = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (MultCtrl) begin
          acc_d    = {32'd0, abs_b};
          opb_d    = abs_a;
          sign_d   = A[31] ^ B[31];
          is_div_d = 1'b0;
          cnt_d    = 6'd0;
          state_d  = MRUN;
        end else if (DivCtrl) begin
          if (B == 32'd0) begin
            div_zero_d = 1'b1;
          end else begin
            acc_d    = {32'd0, abs_a};
            rem_d    = 32'd0;
            opb_d    = abs_b;
            sign_d   = A[31] ^ B[31];
            rsign_d  = A[31];
            is_div_d = 1'b1;
            cnt_d    = 6'd0;
            state_d  = DRUN;
          end
        end
      end

      MRUN: begin
        acc_d = {add_sum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end

      DRUN: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!rem_trial[32]) begin
          rem_d = rem_trial[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          hi_d      = rem_fix;
          lo_d      = quo_fix;
          div_out_d = 1'b1;
        end else begin
          hi_d       = prod_fix[63:32];
          lo_d       = prod_fix[31:0];
          mult_out_d = 1'b1;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign MultOut = mult_out_q;
  assign DivOut  = div_out_q;
  assign divZero = div_zero_q;
  assign busy    = (state_q != IDLE);

endmodule
